// File: rtl/fifo_pkt_pkg.sv
// Shared types and helpers for the length-prefixed byte packer.
package fifo_pkt_pkg;
  typedef enum logic [1:0] {IDLE, PAYLOAD, EMIT} state_t;

  localparam int PKT_LANES = 4;
  localparam int LANE_W    = $clog2(PKT_LANES);

  // Contiguous mask with the low lane_count bits set.
  function automatic logic [63:0] keep_mask(input int lane_count);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < 64; i++)
      if (i < lane_count) m[i] = 1'b1;
    return m;
  endfunction
endpackage

// File: rtl/fifo_byte_packer_lane_assembler.sv
// Lane register file plus keep mask; one byte write or a full clear per cycle.
module lane_assembler
  import fifo_pkt_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int LANES  = PKT_LANES,
  parameter int LW     = $clog2(LANES)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clr,
  input  logic                          wr_en,
  input  logic [LW-1:0]                 wr_lane,
  input  logic [DWIDTH-1:0]             wr_byte,
  output logic [LANES-1:0][DWIDTH-1:0]  data,
  output logic [LANES-1:0]              keep
);
  logic [63:0] next_mask;

  // Lanes fill in order, so keep is always lanes 0..wr_lane.
  assign next_mask = keep_mask(int'(wr_lane) + 1);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    always_ff @(posedge clk or posedge reset) begin
      if (reset)                                 data[g] <= '0;
      else if (clr)                              data[g] <= '0;
      else if (wr_en && wr_lane == LW'(g))       data[g] <= wr_byte;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      keep <= '0;
    else if (clr)   keep <= '0;
    else if (wr_en) keep <= next_mask[LANES-1:0];
  end
endmodule

// File: rtl/fifo_byte_packer.sv
// Pops length-prefixed packets from a byte FIFO and emits LANES-byte words
// with keep/last on a valid/ready port.
module fifo_byte_packer
  import fifo_pkt_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int LANES  = PKT_LANES,
  parameter int CNTW   = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DWIDTH-1:0]         fifo_dout,
  input  logic                      fifo_rdy,
  output logic                      fifo_pop,
  output logic [DWIDTH*LANES-1:0]   word_data,
  output logic [LANES-1:0]          word_keep,
  output logic                      word_last,
  output logic                      word_valid,
  input  logic                      word_ready,
  output logic [CNTW-1:0]           pkt_cnt,
  output logic [CNTW-1:0]           zero_len_cnt,
  output logic                      busy
);
  localparam int LW = $clog2(LANES);

  state_t                        state;
  logic [DWIDTH-1:0]             remaining;
  logic [LW-1:0]                 lane;
  logic                          asm_clr, asm_wr, last_byte, lane_full, hs;
  logic [LANES-1:0][DWIDTH-1:0]  asm_data;

  assign fifo_pop  = fifo_rdy & (state == IDLE | state == PAYLOAD);
  assign hs        = (state == EMIT) & word_ready;
  assign asm_wr    = (state == PAYLOAD) & fifo_rdy;
  // Clear on a non-empty header and on every handshake (last or not).
  assign asm_clr   = ((state == IDLE) & fifo_rdy & (fifo_dout != '0)) | hs;
  assign last_byte = (remaining == DWIDTH'(1));
  assign lane_full = (lane == LW'(LANES - 1));
  assign busy      = (state != IDLE);
  assign word_data = asm_data;

  lane_assembler #(.DWIDTH(DWIDTH), .LANES(LANES), .LW(LW)) u_asm (
    .clk     (clk),
    .reset   (reset),
    .clr     (asm_clr),
    .wr_en   (asm_wr),
    .wr_lane (lane),
    .wr_byte (fifo_dout),
    .data    (asm_data),
    .keep    (word_keep)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      remaining    <= '0;
      lane         <= '0;
      word_last    <= 1'b0;
      word_valid   <= 1'b0;
      pkt_cnt      <= '0;
      zero_len_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (fifo_rdy) begin
          if (fifo_dout == '0) begin
            zero_len_cnt <= zero_len_cnt + 1'b1;
          end else begin
            remaining <= fifo_dout;
            lane      <= '0;
            state     <= PAYLOAD;
          end
        end
        PAYLOAD: if (fifo_rdy) begin
          remaining <= remaining - 1'b1;
          if (last_byte) word_last <= 1'b1;
          if (lane_full || last_byte) begin
            word_valid <= 1'b1;
            state      <= EMIT;
          end else begin
            lane <= lane + 1'b1;
          end
        end
        EMIT: if (word_ready) begin
          word_valid <= 1'b0;
          lane       <= '0;
          if (word_last) begin
            word_last <= 1'b0;
            pkt_cnt   <= pkt_cnt + 1'b1;
            state     <= IDLE;
          end else begin
            state <= PAYLOAD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_byte_packer.sv
// Scoreboard bench: directed packets into a FIFO model, monitor checks emitted words.
module tb_fifo_byte_packer;
  logic        clk = 0, reset = 1;
  logic [7:0]  fifo_dout = '0;
  logic        fifo_rdy = 0, fifo_pop;
  logic [31:0] word_data;
  logic [3:0]  word_keep;
  logic        word_last, word_valid, word_ready = 1, busy;
  logic [15:0] pkt_cnt, zero_len_cnt;

  fifo_byte_packer #(.DWIDTH(8), .LANES(4), .CNTW(16)) dut (
    .clk(clk), .reset(reset), .fifo_dout(fifo_dout), .fifo_rdy(fifo_rdy),
    .fifo_pop(fifo_pop), .word_data(word_data), .word_keep(word_keep),
    .word_last(word_last), .word_valid(word_valid), .word_ready(word_ready),
    .pkt_cnt(pkt_cnt), .zero_len_cnt(zero_len_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] d; logic [3:0] k; logic l; } wexp_t;
  wexp_t      sb[$];
  wexp_t      e;
  logic [7:0] fifo_q[$];
  int         checks = 0, failures = 0, pop_cnt = 0;
  logic       gate = 1, toggle = 0, pop_seen;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  // FIFO model: honour the pop seen at the edge, then present the new head.
  always @(posedge clk) begin
    pop_seen = fifo_pop;
    #1;
    if (pop_seen) begin
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      pop_cnt++;
    end
    gate      = toggle ? !gate : 1'b1;
    fifo_rdy  = gate && fifo_q.size() != 0;
    fifo_dout = fifo_q.size() != 0 ? fifo_q[0] : 8'h00;
  end

  // Monitor: every handshake consumes one scoreboard entry.
  always @(negedge clk) begin
    if (!reset && word_valid && word_ready) begin
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_word: got %h keep %b expected none", word_data, word_keep);
      end else begin
        e = sb.pop_front();
        chk("word_data", 64'(word_data), 64'(e.d));
        chk("word_keep", 64'(word_keep), 64'(e.k));
        chk("word_last", 64'(word_last), 64'(e.l));
      end
    end
  end

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
  endtask

  task automatic expw(input logic [31:0] d, input logic [3:0] k, input logic l);
    wexp_t w;
    w.d = d; w.k = k; w.l = l;
    sb.push_back(w);
  endtask

  task automatic wait_valid(input string n);
    int c = 0;
    while (!word_valid && c < 300) begin @(negedge clk); c++; end
    chk(n, 64'(word_valid), 64'd1);
  endtask

  task automatic wait_drain(input string n, input int limit);
    int c = 0;
    @(negedge clk);
    while ((sb.size() != 0 || fifo_q.size() != 0 || busy) && c < limit) begin
      @(negedge clk); c++;
    end
    chk(n, 64'(c >= limit), 64'd0);
  endtask

  initial begin
    int p0;
    logic [31:0] w;
    @(negedge clk);
    chk("rst_valid", 64'(word_valid), 0);
    chk("rst_data", 64'(word_data), 0);
    chk("rst_keep", 64'(word_keep), 0);
    chk("rst_last", 64'(word_last), 0);
    chk("rst_pkt", 64'(pkt_cnt), 0);
    chk("rst_zlen", 64'(zero_len_cnt), 0);
    chk("rst_busy", 64'(busy), 0);
    @(posedge clk); #2 reset = 0;

    // Five-byte packet: one full word then a single-lane last word.
    p0 = pop_cnt;
    push(8'h05); push(8'h11); push(8'h12); push(8'h13); push(8'h14); push(8'h15);
    expw(32'h14131211, 4'b1111, 0);
    expw(32'h00000015, 4'b0001, 1);
    wait_drain("t1_drain", 200);
    chk("t1_pkt", 64'(pkt_cnt), 1);
    chk("t1_pops", 64'(pop_cnt - p0), 6);

    // Exactly one full word; busy drops the cycle after the handshake.
    push(8'h04); push(8'hA0); push(8'hA1); push(8'hA2); push(8'hA3);
    expw(32'hA3A2A1A0, 4'hF, 1);
    wait_valid("t2_valid");
    chk("t2_busy_hs", 64'(busy), 1);
    @(negedge clk);
    chk("t2_busy_after", 64'(busy), 0);
    wait_drain("t2_drain", 200);
    chk("t2_pkt", 64'(pkt_cnt), 2);

    // Zero-length header is dropped and counted.
    push(8'h00); push(8'h01); push(8'h7E);
    expw(32'h0000007E, 4'b0001, 1);
    wait_drain("t3_drain", 200);
    chk("t3_zlen", 64'(zero_len_cnt), 1);
    chk("t3_pkt", 64'(pkt_cnt), 3);

    // Back-pressure for five cycles on the first word of an 8-byte packet.
    @(posedge clk); #2 word_ready = 0;
    push(8'h08);
    for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
    expw(32'h13121110, 4'hF, 0);
    expw(32'h17161514, 4'hF, 1);
    wait_valid("t4_valid");
    p0 = pop_cnt;
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_data", 64'(word_data), 64'h13121110);
      chk("t4_hold_valid", 64'(word_valid), 1);
      chk("t4_no_pop", 64'(fifo_pop), 0);
      @(negedge clk);
    end
    chk("t4_pops_stalled", 64'(pop_cnt - p0), 0);
    @(posedge clk); #2 word_ready = 1;
    wait_drain("t4_drain", 200);
    chk("t4_pkt", 64'(pkt_cnt), 4);

    // 255-byte packet with FIFO ready toggling every cycle.
    toggle = 1;
    push(8'hFF);
    for (int i = 0; i < 255; i++) push(8'(i));
    for (int i = 0; i < 63; i++) begin
      w = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
      expw(w, 4'hF, 0);
    end
    expw(32'h00FEFDFC, 4'b0111, 1);
    wait_drain("t5_drain", 2000);
    toggle = 0;
    chk("t5_pkt", 64'(pkt_cnt), 5);

    // Reset mid-packet after two payload bytes, then a fresh packet.
    push(8'h06); push(8'hB1); push(8'hB2);
    begin
      int c = 0;
      while (fifo_q.size() != 0 && c < 100) begin @(negedge clk); c++; end
      chk("t6_feed", 64'(c >= 100), 0);
    end
    @(negedge clk);
    chk("t6_busy_mid", 64'(busy), 1);
    @(posedge clk); #2 reset = 1;
    @(posedge clk); #2 reset = 0;
    @(negedge clk);
    chk("t6_valid", 64'(word_valid), 0);
    chk("t6_busy", 64'(busy), 0);
    chk("t6_pkt", 64'(pkt_cnt), 0);
    push(8'h02); push(8'hC1); push(8'hC2);
    expw(32'h0000C2C1, 4'b0011, 1);
    wait_drain("t6_drain", 200);
    chk("t6_pkt_after", 64'(pkt_cnt), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
